// File: rtl/fsm_pattern_gen.sv
// Moore serial pattern transmitter: shifts a latched WIDTH-bit pattern out MSB first,
// CLK_DIV cycles per bit, with forced-low gaps between repeated frames.
module fsm_pattern_gen #(
  parameter int WIDTH     = 8,
  parameter int CLK_DIV   = 50000000,
  parameter int GAP_TICKS = 2
) (
  input  logic             clk,
  input  logic             rst_a_p,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] pattern,
  input  logic [3:0]       repeat_cnt,
  output logic             serial_out,
  output logic             busy,
  output logic             done,
  output logic [3:0]       frame_cnt,
  output logic [1:0]       state_o
);

  localparam int BW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam logic [BW-1:0] BIT_TOP = BW'(WIDTH - 1);
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_MAX = GW'(GAP_TICKS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, GAP = 2'd2, DONE = 2'd3} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [3:0]       rep_q, rep_d;
  logic             cont_q, cont_d;
  logic [3:0]       frame_q, frame_d;
  logic             serial_q, serial_d;
  logic             tick;

  assign tick = (pre_q == PRE_MAX);

  always_comb begin
    state_d  = state_q;
    pat_d    = pat_q;
    bit_d    = bit_q;
    pre_d    = '0;
    gap_d    = gap_q;
    rep_d    = rep_q;
    cont_d   = cont_q;
    frame_d  = frame_q;
    serial_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          pat_d   = pattern;
          rep_d   = repeat_cnt;
          cont_d  = (repeat_cnt == 4'd0);
          bit_d   = BIT_TOP;
          frame_d = 4'd0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        pre_d = tick ? '0 : pre_q + PW'(1);
        if (tick) begin
          if (bit_q != '0) begin
            bit_d = bit_q - BW'(1);
          end else begin
            frame_d = frame_q + 4'd1;
            pre_d   = '0;
            // Continuous mode never consumes rep_left.
            if (cont_q || rep_q > 4'd1) begin
              if (!cont_q) rep_d = rep_q - 4'd1;
              gap_d   = '0;
              state_d = GAP;
            end else begin
              state_d = DONE;
            end
          end
        end
      end
      GAP: begin
        pre_d = tick ? '0 : pre_q + PW'(1);
        if (tick) begin
          if (gap_q == GAP_MAX) begin
            gap_d   = '0;
            bit_d   = BIT_TOP;
            pre_d   = '0;
            state_d = SHIFT;
          end else begin
            gap_d = gap_q + GW'(1);
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Abort dominates everything, including a coincident start.
    if (stop) begin
      state_d = IDLE;
      pre_d   = '0;
      frame_d = frame_q;
    end
    if (state_d == SHIFT) serial_d = pat_d[bit_d];
  end

  always_ff @(posedge clk or posedge rst_a_p) begin
    if (rst_a_p) begin
      state_q  <= IDLE;
      pat_q    <= '0;
      bit_q    <= '0;
      pre_q    <= '0;
      gap_q    <= '0;
      rep_q    <= '0;
      cont_q   <= 1'b0;
      frame_q  <= '0;
      serial_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pat_q    <= pat_d;
      bit_q    <= bit_d;
      pre_q    <= pre_d;
      gap_q    <= gap_d;
      rep_q    <= rep_d;
      cont_q   <= cont_d;
      frame_q  <= frame_d;
      serial_q <= serial_d;
    end
  end

  assign serial_out = serial_q;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign frame_cnt  = frame_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_fsm_pattern_gen.sv
// Directed bench for fsm_pattern_gen: CLK_DIV=4 instance for the main scenarios,
// CLK_DIV=1 instance for the one-bit-per-clock case.
module tb_fsm_pattern_gen;

  logic       clk = 1'b0;
  logic       rst_a_p;
  logic       start, stop;
  logic [7:0] pattern;
  logic [3:0] repeat_cnt;
  logic       serial_out, busy, done;
  logic [3:0] frame_cnt;
  logic [1:0] state_o;

  logic       start1, stop1;
  logic [7:0] pattern1;
  logic [3:0] repeat_cnt1;
  logic       serial1, busy1, done1;
  logic [3:0] frame_cnt1;
  logic [1:0] state1;

  int n_cmp = 0;
  int n_err = 0;

  logic [127:0] w_stream;
  logic [127:0] w_fc;
  int           w_busy, w_done_cnt, w_done_at;

  always #5 clk = ~clk;

  fsm_pattern_gen #(.WIDTH(8), .CLK_DIV(4), .GAP_TICKS(2)) dut (
    .clk(clk), .rst_a_p(rst_a_p), .start(start), .stop(stop),
    .pattern(pattern), .repeat_cnt(repeat_cnt), .serial_out(serial_out),
    .busy(busy), .done(done), .frame_cnt(frame_cnt), .state_o(state_o)
  );

  fsm_pattern_gen #(.WIDTH(8), .CLK_DIV(1), .GAP_TICKS(2)) dut1 (
    .clk(clk), .rst_a_p(rst_a_p), .start(start1), .stop(stop1),
    .pattern(pattern1), .repeat_cnt(repeat_cnt1), .serial_out(serial1),
    .busy(busy1), .done(done1), .frame_cnt(frame_cnt1), .state_o(state1)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Record the busy window of dut; optionally pulse a conflicting start mid-run.
  task automatic watch(input int budget, input int poke_at);
    logic [3:0] last_fc;
    w_stream = '0; w_fc = '0; w_busy = 0; w_done_cnt = 0; w_done_at = 0;
    last_fc = 4'd0;
    while (busy && w_busy < budget) begin
      w_busy++;
      w_stream = {w_stream[126:0], serial_out};
      if (done) begin w_done_cnt++; w_done_at = w_busy; end
      if (frame_cnt != last_fc) begin w_fc = {w_fc[123:0], frame_cnt}; last_fc = frame_cnt; end
      if (w_busy == poke_at) begin
        start = 1'b1; pattern = 8'h3C; repeat_cnt = 4'd5;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    check("watch_bound", 128'(w_busy < budget), 128'd1);
  endtask

  initial begin
    logic [3:0] last_fc;
    int         busy_sum, done_sum;

    rst_a_p = 1'b1;
    start = 1'b0; stop = 1'b0; pattern = '0; repeat_cnt = '0;
    start1 = 1'b0; stop1 = 1'b0; pattern1 = '0; repeat_cnt1 = '0;
    #12 rst_a_p = 1'b0;
    tick();

    // Reset state
    check("rst_serial", serial_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_state", state_o, 0);

    // Single frame 0111_0000
    pattern = 8'b0111_0000; repeat_cnt = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    watch(200, 0);
    check("t1_busy_len", w_busy, 33);
    check("t1_done_at", w_done_at, 33);
    check("t1_done_cnt", w_done_cnt, 1);
    check("t1_stream", w_stream, 128'h1FFE0000);
    check("t1_fc_hist", w_fc, 128'h1);
    check("t1_after_busy", busy, 0);
    check("t1_after_done", done, 0);
    check("t1_frame_hold", frame_cnt, 1);

    // Three frames of A5 with an ignored start 10 cycles in
    tick();
    pattern = 8'hA5; repeat_cnt = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    watch(400, 10);
    check("t2_busy_len", w_busy, 113);
    check("t2_done_at", w_done_at, 113);
    check("t2_done_cnt", w_done_cnt, 1);
    check("t2_stream", w_stream,
          {15'd0, 32'hF0F00F0F, 8'h00, 32'hF0F00F0F, 8'h00, 32'hF0F00F0F, 1'b0});
    check("t2_fc_hist", w_fc, 128'h123);
    check("t2_after_busy", busy, 0);
    check("t2_frame_hold", frame_cnt, 3);

    // Continuous FF, wrap of frame_cnt, stop mid-bit
    tick();
    pattern = 8'hFF; repeat_cnt = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    w_stream = '0; w_fc = '0; last_fc = 4'd0; busy_sum = 0; done_sum = 0;
    for (int n = 1; n <= 686; n++) begin
      if (n <= 80) w_stream = {w_stream[126:0], serial_out};
      if (busy) busy_sum++;
      if (done) done_sum++;
      if (frame_cnt != last_fc) begin w_fc = {w_fc[123:0], frame_cnt}; last_fc = frame_cnt; end
      if (n != 686) tick();
    end
    check("t3_stream80", w_stream, {48'd0, 32'hFFFFFFFF, 8'h00, 32'hFFFFFFFF, 8'h00});
    check("t3_fc_wrap", w_fc, 128'h123456789ABCDEF01);
    check("t3_busy_all", busy_sum, 686);
    check("t3_no_done", done_sum, 0);
    check("t3_pre_stop_serial", serial_out, 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("t3_stop_serial", serial_out, 0);
    check("t3_stop_busy", busy, 0);
    check("t3_stop_done", done, 0);
    check("t3_stop_frame_hold", frame_cnt, 1);
    tick();
    check("t3_stop_idle_done", done, 0);

    // start and stop together in IDLE, then start alone
    pattern = 8'h80; repeat_cnt = 4'd2; start = 1'b1; stop = 1'b1;
    tick();
    check("t5_both_busy", busy, 0);
    check("t5_both_serial", serial_out, 0);
    stop = 1'b0;
    tick();
    start = 1'b0;
    check("t5_accept_busy", busy, 1);
    check("t5_accept_serial", serial_out, 1);
    check("t5_frame_cleared", frame_cnt, 0);

    // Async reset between edges during the second frame
    for (int i = 0; i < 41; i++) tick();
    check("t6_pre_serial", serial_out, 1);
    check("t6_pre_frame", frame_cnt, 1);
    check("t6_pre_busy", busy, 1);
    #2 rst_a_p = 1'b1;
    #1;
    check("t6_rst_serial", serial_out, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_done", done, 0);
    check("t6_rst_frame", frame_cnt, 0);
    #1 rst_a_p = 1'b0;
    tick();

    // CLK_DIV=1: one bit per clock
    pattern1 = 8'h81; repeat_cnt1 = 4'd1; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    w_stream = '0; busy_sum = 0; done_sum = 0; w_done_at = 0;
    for (int n = 1; n <= 9; n++) begin
      w_stream = {w_stream[126:0], serial1};
      if (busy1) busy_sum++;
      if (done1) begin done_sum++; w_done_at = n; end
      tick();
    end
    check("t6b_stream", w_stream, 128'h102);
    check("t6b_busy_len", busy_sum, 9);
    check("t6b_done_at", w_done_at, 9);
    check("t6b_done_cnt", done_sum, 1);
    check("t6b_idle_busy", busy1, 0);
    check("t6b_frame", frame_cnt1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
